// File: rtl/nibble_scan_sequencer.sv
// Nibble bank feeder for a 4-bit 8:1 mux: loads eight nibbles, then scans the mux select.
// Optional macro SCAN_LOOP_EN: scan repeats until start requests a stop.
module nibble_scan_sequencer #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  in_data,
    output logic        in_ready,
    input  logic        start,
    output logic [0:31] w,
    output logic [2:0]  s,
    output logic        scan_valid,
    output logic        full,
    output logic        done
);

    typedef enum logic [1:0] {LOAD, READY, SCAN} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state;
    logic [3:0] slot [8];
    logic [2:0] wr_ptr;
    logic [7:0] hold_cnt;
    logic       pass_end;
    logic       leave_scan;

    // Ascending bus: in_data[3] of slot k lands on w[4k], so slot 0 is the top hex digit.
    for (genvar k = 0; k < 8; k++) begin : g_bus
        assign w[4*k +: 4] = slot[k];
    end

    assign pass_end = (state == SCAN) && (hold_cnt == HOLD_LAST) && (s == 3'd7);

`ifdef SCAN_LOOP_EN
    logic stop_req;

    // A start seen on the final cycle of a pass still counts for that pass.
    assign leave_scan = stop_req | start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_req <= 1'b0;
        end else if (pass_end && leave_scan) begin
            stop_req <= 1'b0;
        end else if (state == SCAN && start) begin
            stop_req <= 1'b1;
        end
    end
`else
    assign leave_scan = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LOAD;
            wr_ptr     <= 3'd0;
            hold_cnt   <= 8'd0;
            s          <= 3'd0;
            in_ready   <= 1'b1;
            scan_valid <= 1'b0;
            full       <= 1'b0;
            done       <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                slot[k] <= 4'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        slot[wr_ptr] <= in_data;
                        wr_ptr       <= wr_ptr + 3'd1;
                        if (wr_ptr == 3'd7) begin
                            state    <= READY;
                            in_ready <= 1'b0;
                            full     <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (start) begin
                        state      <= SCAN;
                        s          <= 3'd0;
                        hold_cnt   <= 8'd0;
                        scan_valid <= 1'b1;
                        full       <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= 8'd0;
                        s        <= s + 3'd1;
                        if (pass_end) begin
                            done <= 1'b1;
                            if (leave_scan) begin
                                state      <= LOAD;
                                scan_valid <= 1'b0;
                                in_ready   <= 1'b1;
                            end
                        end
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_scan_sequencer.sv
// Directed bench for nibble_scan_sequencer: HOLD_CYCLES=1 and HOLD_CYCLES=3 instances.
// Loop-mode scenario is exercised when SCAN_LOOP_EN is defined.
module tb_nibble_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        valid1 = 1'b0, start1 = 1'b0;
    logic [3:0]  data1 = 4'd0;
    logic        ready1, sv1, full1, done1;
    logic [0:31] w1;
    logic [2:0]  s1;

    logic        valid3 = 1'b0, start3 = 1'b0;
    logic [3:0]  data3 = 4'd0;
    logic        ready3, sv3, full3, done3;
    logic [0:31] w3;
    logic [2:0]  s3;

    int checks = 0;
    int passed = 0;

    nibble_scan_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(valid1), .in_data(data1), .in_ready(ready1),
        .start(start1), .w(w1), .s(s1), .scan_valid(sv1), .full(full1), .done(done1)
    );

    nibble_scan_sequencer #(.HOLD_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(valid3), .in_data(data3), .in_ready(ready3),
        .start(start3), .w(w3), .s(s3), .scan_valid(sv3), .full(full3), .done(done3)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        else passed++;
    endtask

    task automatic load1(input logic [3:0] a, b, c, d, e, f, g, h);
        logic [3:0] v [8];
        v = '{a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) begin
            valid1 = 1'b1;
            data1  = v[i];
            step();
        end
        valid1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        valid1 = 1'b1;
        data1  = 4'h9;
        step();
        valid1 = 1'b0;
        check("preload_w", w1, 32'h9000_0000);
        #2 rst = 1'b1;
        #2;
        check("rst_in_ready", {31'd0, ready1}, 32'd1);
        check("rst_w", w1, 32'h0);
        check("rst_s", {29'd0, s1}, 32'd0);
        check("rst_flags", {29'd0, sv1, full1, done1}, 32'd0);
        check("rst_w3", w3, 32'h0);
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_load();
        load1(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8);
        check("load_w", w1, 32'h1234_5678);
        check("load_full", {31'd0, full1}, 32'd1);
        check("load_ready", {31'd0, ready1}, 32'd0);
        // extra valid beat after the bank filled must be dropped
        valid1 = 1'b1;
        data1  = 4'hF;
        step();
        valid1 = 1'b0;
        check("no_overwrite_w", w1, 32'h1234_5678);
        check("still_full", {31'd0, full1}, 32'd1);
    endtask

    task automatic test_scan_hold1();
        int dcount = 0;
        start1 = 1'b1;
        step();
        check("scan_start_full", {31'd0, full1}, 32'd0);
        step();
        start1 = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("scan_s", {29'd0, s1}, 32'(i));
            check("scan_valid", {31'd0, sv1}, 32'd1);
            check("scan_f", {28'd0, w1[4*s1 +: 4]}, 32'(i + 1));
            if (done1) dcount++;
            step();
        end
        check("scan_done", {31'd0, done1}, 32'd1);
        check("scan_exit_ready", {31'd0, ready1}, 32'd1);
        check("scan_exit_sv", {31'd0, sv1}, 32'd0);
        check("scan_exit_s", {29'd0, s1}, 32'd0);
        check("scan_early_done", 32'(dcount), 32'd0);
        step();
        check("done_one_cycle", {31'd0, done1}, 32'd0);
        check("slots_kept", w1, 32'h1234_5678);
    endtask

    task automatic test_hold3();
        logic [3:0] v [8];
        int dcount = 0;
        v = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        for (int i = 0; i < 8; i++) begin
            valid3 = 1'b1;
            data3  = v[i];
            step();
            valid3 = 1'b0;
            data3  = 4'h5;
            step();
        end
        check("h3_w", w3, 32'hABCD_EF01);
        check("h3_full", {31'd0, full3}, 32'd1);
        start3 = 1'b1;
        step();
        for (int i = 0; i < 24; i++) begin
            if (i == 1) start3 = 1'b0;
            check("h3_s", {29'd0, s3}, 32'(i / 3));
            if (done3) dcount++;
            step();
        end
        start3 = 1'b0;
        check("h3_done", {31'd0, done3}, 32'd1);
        check("h3_ready", {31'd0, ready3}, 32'd1);
        check("h3_early_done", 32'(dcount), 32'd0);
    endtask

    task automatic test_reset_mid_scan();
        int guard = 0;
        load1(4'h8, 4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1);
        check("r_load_w", w1, 32'h8765_4321);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        while (s1 != 3'd3 && guard < 20) begin
            step();
            guard++;
        end
        check("r_reach_s3", {29'd0, s1}, 32'd3);
        #2 rst = 1'b1;
        #1;
        check("r_s", {29'd0, s1}, 32'd0);
        check("r_sv", {31'd0, sv1}, 32'd0);
        check("r_w", w1, 32'h0);
        check("r_ready", {31'd0, ready1}, 32'd1);
        step();
        rst = 1'b0;
        step();
        valid1 = 1'b1;
        data1  = 4'hC;
        step();
        valid1 = 1'b0;
        check("r_reload_slot0", w1, 32'hC000_0000);
        // return to a clean bank for any following scenario
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

`ifdef SCAN_LOOP_EN
    task automatic test_loop();
        int dcount = 0;
        int passes = 0;
        int cyc = 0;
        load1(4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        while (sv1 && cyc < 40) begin
            start1 = (passes == 1 && s1 == 3'd2) ? 1'b1 : 1'b0;
            step();
            cyc++;
            if (done1) begin
                dcount++;
                passes++;
                if (passes == 1) check("loop_wrap_s", {28'd0, sv1, s1}, 32'h8);
            end
        end
        start1 = 1'b0;
        check("loop_done_count", 32'(dcount), 32'd2);
        check("loop_cycles", 32'(cyc), 32'd16);
        check("loop_exit_ready", {31'd0, ready1}, 32'd1);
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_scan_hold1();
        test_hold3();
        test_reset_mid_scan();
`ifdef SCAN_LOOP_EN
        test_loop();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
